// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: shared encodings for the execute unit.
//   ALU_*      4-bit ALU operation codes (ALUOp)
//   MDU_*      3-bit multiply/divide operation codes (mdu_op)
//   mdu_state_t  iterative MDU controller states
//   mdu_is_long  true for ops that run the iterative datapath
package alu_mdu_pkg;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_NOR  = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SRA  = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_t;

    // Multiply and divide ops occupy the iterative datapath.
    function automatic logic mdu_is_long(input logic [2:0] op);
        return (op <= MDU_DIVU);
    endfunction

endpackage

// File: rtl/alu_mdu_mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit with HI/LO registers.
//   clk, rstn   clock, synchronous active-low reset
//   a, b        operands, sampled only when a start is accepted in IDLE
//   op, start   operation request (MDU_* encoding)
//   busy        high while RUN or FIX; starts are ignored meanwhile
//   hi, lo      architectural HI/LO registers
module mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int SHW = $clog2(WIDTH);

    mdu_state_t       state_reg, state_next;
    logic [SHW-1:0]   count_reg;
    // acc_reg: product high half / partial remainder
    // shf_reg: multiplier shifting out / dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] acc_reg, shf_reg, opb_reg;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic             is_div_reg, neg_q_reg, neg_r_reg, div0_reg;

    logic             op_signed;
    logic [WIDTH-1:0] mag_a, mag_b;

    // Operands are reduced to magnitudes up front; the most-negative value
    // maps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    assign op_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign mag_a     = (op_signed && a[WIDTH-1]) ? -a : a;
    assign mag_b     = (op_signed && b[WIDTH-1]) ? -b : b;

    // Shift-add multiply step
    logic [WIDTH:0] add_sum;
    assign add_sum = {1'b0, acc_reg} + (shf_reg[0] ? {1'b0, opb_reg} : '0);

    // Restoring divide step. The partial remainder stays below the divisor,
    // so the difference always fits in WIDTH bits when it is taken.
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff;
    assign rem_shift = {acc_reg, shf_reg[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, opb_reg});
    assign rem_diff  = rem_shift[WIDTH-1:0] - opb_reg;

    // Sign correction. MIN / -1 needs no special case: magnitudes give
    // q = 2^(WIDTH-1), r = 0, and no negation applies, so lo = MIN.
    // Divide by zero leaves r = |A|, which the dividend-sign fix turns back
    // into A; only the quotient is forced to all ones.
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix;
    assign prod     = {acc_reg, shf_reg};
    assign prod_fix = neg_q_reg ? -prod : prod;
    assign q_fix    = div0_reg ? '1 : (neg_q_reg ? -shf_reg : shf_reg);
    assign r_fix    = neg_r_reg ? -acc_reg : acc_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MDU_IDLE: if (start && mdu_is_long(op)) state_next = MDU_RUN;
            MDU_RUN:  if (count_reg == SHW'(WIDTH - 1)) state_next = MDU_FIX;
            MDU_FIX:  state_next = MDU_IDLE;
            default:  state_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= MDU_IDLE;
            count_reg  <= '0;
            acc_reg    <= '0;
            shf_reg    <= '0;
            opb_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            div0_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                MDU_IDLE: begin
                    if (start) begin
                        if (mdu_is_long(op)) begin
                            acc_reg    <= '0;
                            shf_reg    <= mag_a;
                            opb_reg    <= mag_b;
                            count_reg  <= '0;
                            is_div_reg <= (op == MDU_DIV) || (op == MDU_DIVU);
                            neg_q_reg  <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r_reg  <= op_signed && a[WIDTH-1];
                            div0_reg   <= (b == '0);
                        end else if (op == MDU_MTHI) begin
                            hi_reg <= a;
                        end else if (op == MDU_MTLO) begin
                            lo_reg <= a;
                        end
                    end
                end
                MDU_RUN: begin
                    count_reg <= count_reg + SHW'(1);
                    if (is_div_reg) begin
                        acc_reg <= rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
                        shf_reg <= {shf_reg[WIDTH-2:0], rem_ge};
                    end else begin
                        acc_reg <= add_sum[WIDTH:1];
                        shf_reg <= {add_sum[0], shf_reg[WIDTH-1:1]};
                    end
                end
                MDU_FIX: begin
                    if (is_div_reg) begin
                        hi_reg <= r_fix;
                        lo_reg <= q_fix;
                    end else begin
                        {hi_reg, lo_reg} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg != MDU_IDLE);
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage execute unit; combinational ALU plus iterative MDU.
//   clk, rstn                clock, synchronous active-low reset
//   A, B, ALUOp              ALU operands and operation (ALU_* encoding)
//   C, Zero, Overflow        combinational ALU result and flags
//   mdu_op, mdu_start        MDU request (MDU_* encoding)
//   mdu_busy, hi, lo         MDU status and HI/LO registers
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] C,
    output logic             Zero,
    output logic             Overflow,
    input  logic [2:0]       mdu_op,
    input  logic             mdu_start,
    output logic             mdu_busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic [SHW-1:0] shamt;
    assign shamt = A[SHW-1:0];

    always_comb begin
        C = A;
        case (ALUOp)
            ALU_ADD:  C = A + B;
            ALU_SUB:  C = A - B;
            ALU_AND:  C = A & B;
            ALU_OR:   C = A | B;
            ALU_XOR:  C = A ^ B;
            ALU_NOR:  C = ~(A | B);
            ALU_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_SLL:  C = B << shamt;
            ALU_SRL:  C = B >> shamt;
            ALU_SRA:  C = $signed(B) >>> shamt;
            ALU_LUI:  C = B << 16;
            default:  C = A;
        endcase
    end

    assign Zero = (C == '0);

    always_comb begin
        Overflow = 1'b0;
        if (ALUOp == ALU_ADD)
            Overflow = (A[WIDTH-1] == B[WIDTH-1]) && (C[WIDTH-1] != A[WIDTH-1]);
        else if (ALUOp == ALU_SUB)
            Overflow = (A[WIDTH-1] != B[WIDTH-1]) && (C[WIDTH-1] != A[WIDTH-1]);
    end

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu (
        .clk   (clk),
        .rstn  (rstn),
        .a     (A),
        .b     (B),
        .op    (mdu_op),
        .start (mdu_start),
        .busy  (mdu_busy),
        .hi    (hi),
        .lo    (lo)
    );

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed-vector bench for alu_mdu at WIDTH=32.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] A, B, C, hi, lo;
    logic [3:0]  ALUOp;
    logic [2:0]  mdu_op;
    logic        mdu_start, mdu_busy, Zero, Overflow;

    int pass_cnt  = 0;
    int total_cnt = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .A         (A),
        .B         (B),
        .ALUOp     (ALUOp),
        .C         (C),
        .Zero      (Zero),
        .Overflow  (Overflow),
        .mdu_op    (mdu_op),
        .mdu_start (mdu_start),
        .mdu_busy  (mdu_busy),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("ok   %-14s got %h", tag, got);
        end else begin
            $display("FAIL %-14s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_c,
                       input logic exp_z, input logic exp_v);
        ALUOp = op; A = a; B = b;
        #1;
        check({tag, ".C"}, C, exp_c);
        check({tag, ".Z"}, {31'd0, Zero}, {31'd0, exp_z});
        check({tag, ".V"}, {31'd0, Overflow}, {31'd0, exp_v});
    endtask

    // Issue op at a negedge, count busy cycles (bounded), then check HI/LO.
    task automatic mdu(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo);
        int n;
        @(negedge clk);
        A = a; B = b; mdu_op = op; mdu_start = 1'b1;
        @(negedge clk);
        mdu_start = 1'b0;
        n = 0;
        while (mdu_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({tag, ".cyc"}, n, 33);
        check({tag, ".hi"}, hi, exp_hi);
        check({tag, ".lo"}, lo, exp_lo);
    endtask

    initial begin
        int n;
        rstn = 1'b0; A = '0; B = '0; ALUOp = ALU_NOP; mdu_op = MDU_MULT; mdu_start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.busy", {31'd0, mdu_busy}, 32'd0);
        check("rst.hi", hi, 32'd0);
        check("rst.lo", lo, 32'd0);
        rstn = 1'b1;

        // ALU vectors
        alu("add_ovf", ALU_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1);
        alu("sub_zero", ALU_SUB, 32'h5,        32'h5,        32'h0,        1'b1, 1'b0);
        alu("sub_ovf", ALU_SUB,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1);
        alu("sra",     ALU_SRA,  32'h4,        32'h80000000, 32'hF8000000, 1'b0, 1'b0);
        alu("srl",     ALU_SRL,  32'h4,        32'h80000000, 32'h08000000, 1'b0, 1'b0);
        alu("sll",     ALU_SLL,  32'h1F,       32'h1,        32'h80000000, 1'b0, 1'b0);
        alu("slt",     ALU_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0);
        alu("sltu",    ALU_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0);
        alu("lui",     ALU_LUI,  32'h0,        32'h1234,     32'h12340000, 1'b0, 1'b0);
        alu("nor",     ALU_NOR,  32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F, 1'b0, 1'b0);
        alu("xor",     ALU_XOR,  32'hFF00FF00, 32'h0FF00FF0, 32'hF0F0F0F0, 1'b0, 1'b0);
        alu("nop",     ALU_NOP,  32'hDEADBEEF, 32'h1,        32'hDEADBEEF, 1'b0, 1'b0);

        // MDU vectors
        mdu("mult",    MDU_MULT,  32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1);
        mdu("multu",   MDU_MULTU, 32'hFFFFFFFD, 32'h5,        32'h00000004, 32'hFFFFFFF1);
        mdu("divu",    MDU_DIVU,  32'h7,        32'h2,        32'h1,        32'h3);
        mdu("div_neg", MDU_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        mdu("div0",    MDU_DIV,   32'h1234,     32'h0,        32'h1234,     32'hFFFFFFFF);
        mdu("divu0",   MDU_DIVU,  32'hFFFFFFF0, 32'h0,        32'hFFFFFFF0, 32'hFFFFFFFF);
        mdu("div_min", MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);

        // Start while busy is ignored; HI/LO hold through RUN
        @(negedge clk);
        A = 32'h3; B = 32'h5; mdu_op = MDU_MULT; mdu_start = 1'b1;
        @(negedge clk);
        mdu_start = 1'b0;
        n = 1;
        repeat (9) begin @(negedge clk); n++; end
        A = 32'd100; B = 32'd7; mdu_op = MDU_DIVU; mdu_start = 1'b1;
        check("ign.hold_hi", hi, 32'h0);
        check("ign.hold_lo", lo, 32'h80000000);
        @(negedge clk);
        mdu_start = 1'b0; n++;
        while (mdu_busy && n < 100) begin
            @(negedge clk);
            if (mdu_busy) n++;
        end
        check("ign.cyc", n, 33);
        check("ign.hi", hi, 32'h0);
        check("ign.lo", lo, 32'hF);

        // MTLO / MTHI single-cycle writes
        @(negedge clk);
        A = 32'hAA; mdu_op = MDU_MTLO; mdu_start = 1'b1;
        @(negedge clk);
        mdu_start = 1'b0;
        check("mtlo.lo", lo, 32'hAA);
        check("mtlo.busy", {31'd0, mdu_busy}, 32'd0);
        A = 32'h55; mdu_op = MDU_MTHI; mdu_start = 1'b1;
        @(negedge clk);
        mdu_start = 1'b0;
        check("mthi.hi", hi, 32'h55);
        check("mthi.lo", lo, 32'hAA);

        // Undefined op is ignored
        A = 32'h77; mdu_op = 3'd7; mdu_start = 1'b1;
        @(negedge clk);
        mdu_start = 1'b0;
        check("undef.busy", {31'd0, mdu_busy}, 32'd0);
        check("undef.hi", hi, 32'h55);

        // Reset mid-DIV aborts; a fresh op then completes
        A = 32'd100; B = 32'd7; mdu_op = MDU_DIV; mdu_start = 1'b1;
        @(negedge clk);
        mdu_start = 1'b0;
        repeat (14) @(negedge clk);
        check("abort.busy_mid", {31'd0, mdu_busy}, 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        check("abort.busy", {31'd0, mdu_busy}, 32'd0);
        check("abort.hi", hi, 32'h0);
        check("abort.lo", lo, 32'h0);
        mdu("after_rst", MDU_DIV, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
